// File: rtl/pc_sequencer_if.sv
// Vector-fetch port between the PC sequencer and instruction memory.
// A beat transfers on any cycle where vec_rd and vec_valid are both high; vec_rd
// holds with a stable vec_addr until that happens, and vec_valid while vec_rd is low is ignored.
interface pc_sequencer_if;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic [15:0] vec_data;
    logic        vec_valid;

    modport master (
        output vec_rd,
        output vec_addr,
        input  vec_data,
        input  vec_valid
    );

    modport slave (
        input  vec_rd,
        input  vec_addr,
        output vec_data,
        output vec_valid
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection: boot vector fetch, increment, branch, stall and interrupt
// entry through a two-halfword vector fetch.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'h0,
    parameter logic [31:0] INT_VEC_ADDR   = 32'h2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_in,
    input  logic          instr_size,
    input  logic [31:0]   current_pc,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          int_req,
    pc_sequencer_if.master vec,
    output logic [31:0]   next_pc,
    output logic          pc_stall,
    output logic          flush,
    output logic          int_ack,
    output logic [31:0]   saved_pc,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        BOOT_LO = 3'd0,
        BOOT_HI = 3'd1,
        RUN     = 3'd2,
        INT_LO  = 3'd3,
        INT_HI  = 3'd4
    } state_t;

    state_t      state;
    logic        pending;
    logic [15:0] lo_half;
    logic        accept;
    logic [31:0] inc_pc;
    logic [31:0] vec_base;

    assign state_dbg = state;
    assign inc_pc    = current_pc + 32'd1 + {31'd0, instr_size};
    assign vec_base  = (state == INT_LO || state == INT_HI) ? INT_VEC_ADDR : RESET_VEC_ADDR;

    always_comb begin
        next_pc      = 32'd0;
        pc_stall     = 1'b1;
        flush        = 1'b1;
        vec.vec_rd   = 1'b0;
        vec.vec_addr = vec_base;
        int_ack      = 1'b0;
        accept       = 1'b0;
        case (state)
            BOOT_HI, INT_HI: begin
                vec.vec_rd   = 1'b1;
                vec.vec_addr = vec_base + 32'd1;
                next_pc      = {vec.vec_data, lo_half};
                pc_stall     = ~vec.vec_valid;
            end
            RUN: begin
                next_pc  = inc_pc;
                pc_stall = 1'b0;
                flush    = 1'b0;
                // Branch beats everything; a pending interrupt waits for a quiet cycle.
                if (branch_taken) begin
                    next_pc = branch_target;
                    flush   = 1'b1;
                end else if (pending && !stall_in) begin
                    accept   = 1'b1;
                    int_ack  = 1'b1;
                    flush    = 1'b1;
                    pc_stall = 1'b1;
                end else if (stall_in) begin
                    pc_stall = 1'b1;
                end
            end
            default: begin
                vec.vec_rd = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT_LO;
            pending  <= 1'b0;
            lo_half  <= 16'd0;
            saved_pc <= 32'd0;
        end else begin
            pending <= accept ? 1'b0 : (pending | int_req);
            case (state)
                BOOT_LO: if (vec.vec_valid) begin
                    lo_half <= vec.vec_data;
                    state   <= BOOT_HI;
                end
                BOOT_HI: if (vec.vec_valid) state <= RUN;
                INT_LO: if (vec.vec_valid) begin
                    lo_half <= vec.vec_data;
                    state   <= INT_HI;
                end
                INT_HI: if (vec.vec_valid) state <= RUN;
                RUN: if (accept) begin
                    saved_pc <= current_pc;
                    state    <= INT_LO;
                end
                default: state <= BOOT_LO;
            endcase
        end
    end

endmodule
